// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the memory stage
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic {IDLE, DONE} memacc_state_t;

  localparam word_t SC_PASS = 32'd1;
  localparam word_t SC_FAIL = 32'd0;
endpackage

// File: rtl/link_reg.sv
// rtl/link_reg.sv - LL/SC link register with write and snoop invalidation
module link_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  set,
  input  logic  wclr,
  input  word_t addr,
  input  logic  ccinv,
  input  word_t ccsnoopaddr,
  input  logic  memSC,
  output logic  scfail
);

  logic  linkvalid;
  word_t linkaddr;
  logic  clr;

  assign clr    = (wclr && addr == linkaddr) || (ccinv && ccsnoopaddr == linkaddr);
  assign scfail = memSC && (!linkvalid || linkaddr != addr);

  // A new LL overrides any invalidation arriving in the same cycle
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      linkvalid <= 1'b0;
      linkaddr  <= '0;
    end else if (set) begin
      linkvalid <= 1'b1;
      linkaddr  <= addr;
    end else if (clr) begin
      linkvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage data-cache access, result hold and stall counter
module mem_access
  import cpu_types_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            memMemRead,
  input  logic            memMemWrite,
  input  logic            memLL,
  input  logic            memSC,
  input  word_t           memaddr,
  input  word_t           memstore,
  input  logic            memW,
  input  logic            memRST,
  input  logic            dhit,
  input  word_t           dmemload,
  input  logic            ccinv,
  input  word_t           ccsnoopaddr,
  output logic            dmemREN,
  output logic            dmemWEN,
  output word_t           dmemaddr,
  output word_t           dmemstore,
  output word_t           memdmemload,
  output logic            memStall,
  output logic [CNTW-1:0] stallcnt
);

  memacc_state_t state;
  word_t         hold;
  word_t         result;
  logic          op;
  logic          scfail;
  logic          complete;
  logic          flush;
  logic          upd;

  assign op       = memMemRead | memMemWrite;
  assign flush    = memW & memRST;
  assign complete = dhit | (scfail & op);
  assign upd      = (state == IDLE) & ~flush;

  assign dmemaddr  = memaddr;
  assign dmemstore = memstore;

  link_reg u_link (
    .CLK         (CLK),
    .nRST        (nRST),
    .set         (upd & memMemRead & memLL & dhit),
    .wclr        (upd & memMemWrite & dhit & ~scfail),
    .addr        (memaddr),
    .ccinv       (ccinv),
    .ccsnoopaddr (ccsnoopaddr),
    .memSC       (memSC),
    .scfail      (scfail)
  );

  always_comb begin
    result = '0;
    if (memMemRead)
      result = dmemload;
    else if (memMemWrite && memSC)
      result = (!scfail && dhit) ? SC_PASS : SC_FAIL;
  end

  // Outputs are gated by reset so a pending request drops without waiting for a clock
  always_comb begin
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    memStall    = 1'b0;
    memdmemload = '0;
    if (nRST) begin
      if (state == IDLE) begin
        dmemREN     = memMemRead;
        dmemWEN     = memMemWrite & ~scfail;
        memStall    = op & ~dhit & ~scfail;
        memdmemload = result;
      end else begin
        memdmemload = hold;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            hold <= '0;
          end else if (complete && !memW) begin
            hold  <= result;
            state <= DONE;
          end
        end
        DONE: begin
          if (memW) begin
            state <= IDLE;
            if (memRST) hold <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stallcnt <= '0;
    else if (memStall && stallcnt != '1)
      stallcnt <= stallcnt + 1'b1;
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized and directed self-checking bench for mem_access
module tb_mem_access;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        memMemRead, memMemWrite, memLL, memSC;
  logic [31:0] memaddr, memstore, dmemload, ccsnoopaddr;
  logic        memW, memRST, dhit, ccinv;
  logic        dmemREN, dmemWEN, memStall;
  logic [31:0] dmemaddr, dmemstore, memdmemload;
  logic [15:0] stallcnt;

  int nerr = 0;
  int nchk = 0;

  bit          m_done;
  logic [31:0] m_hold;
  bit          m_lv;
  logic [31:0] m_la;
  int          m_cnt;
  bit          e_ren, e_wen, e_stall, m_scfail;
  logic [31:0] e_load;
  bit          o_ren, o_stall;

  mem_access dut (
    .CLK(CLK), .nRST(nRST), .memMemRead(memMemRead), .memMemWrite(memMemWrite),
    .memLL(memLL), .memSC(memSC), .memaddr(memaddr), .memstore(memstore),
    .memW(memW), .memRST(memRST), .dhit(dhit), .dmemload(dmemload),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .memdmemload(memdmemload),
    .memStall(memStall), .stallcnt(stallcnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_done = 0; m_hold = 0; m_lv = 0; m_la = 0; m_cnt = 0;
  endtask

  // What the stage should present this cycle, from the operation rules alone
  task automatic model_expect();
    bit op;
    op = memMemRead || memMemWrite;
    m_scfail = memSC && (!m_lv || m_la != memaddr);
    if (m_done) begin
      e_ren = 0; e_wen = 0; e_stall = 0; e_load = m_hold;
    end else begin
      e_ren   = memMemRead;
      e_wen   = memMemWrite && !m_scfail;
      e_stall = op && !dhit && !m_scfail;
      if (memMemRead)                e_load = dmemload;
      else if (memMemWrite && memSC) e_load = (!m_scfail && dhit) ? 32'd1 : 32'd0;
      else                           e_load = 32'd0;
    end
  endtask

  task automatic model_clock();
    bit flush, op, done_now, setl, clrl;
    op = memMemRead || memMemWrite;
    flush = memW && memRST;
    done_now = m_done;
    if (e_stall && m_cnt < 65535) m_cnt++;
    setl = 0; clrl = 0;
    if (!done_now && !flush) begin
      setl = memMemRead && memLL && dhit;
      clrl = memMemWrite && dhit && !m_scfail && memaddr == m_la;
    end
    if (ccinv && ccsnoopaddr == m_la) clrl = 1;
    if (setl) begin m_lv = 1; m_la = memaddr; end
    else if (clrl) m_lv = 0;
    if (done_now) begin
      if (memW) begin m_done = 0; if (memRST) m_hold = 0; end
    end else if (flush) begin
      m_hold = 0;
    end else if ((dhit || (m_scfail && op)) && !memW) begin
      m_done = 1; m_hold = e_load;
    end
  endtask

  // Called just after a posedge with inputs already applied
  task automatic cycle();
    #3;
    model_expect();
    o_ren = dmemREN; o_stall = memStall;
    chk("dmemREN", {31'd0, dmemREN}, {31'd0, e_ren});
    chk("dmemWEN", {31'd0, dmemWEN}, {31'd0, e_wen});
    chk("memStall", {31'd0, memStall}, {31'd0, e_stall});
    chk("memdmemload", memdmemload, e_load);
    chk("dmemaddr", dmemaddr, memaddr);
    @(posedge CLK);
    model_clock();
    #1;
    chk("stallcnt", {16'd0, stallcnt}, m_cnt[31:0]);
  endtask

  task automatic idle_in();
    memMemRead = 0; memMemWrite = 0; memLL = 0; memSC = 0;
    memaddr = 0; memstore = 0; memW = 1; memRST = 0; dhit = 0;
    dmemload = 0; ccinv = 0; ccsnoopaddr = 0;
  endtask

  initial begin
    int base, nren, nstall;
    idle_in();
    memW = 0;
    nRST = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_ren", {31'd0, dmemREN}, 32'd0);
    chk("reset_load", memdmemload, 32'd0);
    chk("reset_stallcnt", {16'd0, stallcnt}, 32'd0);
    nRST = 1;
    memW = 1;
    cycle();

    // LW hit
    memMemRead = 1; memaddr = 32'h100; dhit = 1; dmemload = 32'hDEADBEEF;
    base = m_cnt;
    cycle();
    chk("lw_hit_stall", {31'd0, o_stall}, 32'd0);
    chk("lw_hit_cnt", {16'd0, stallcnt}, base[31:0]);

    // LW miss, dhit on 4th cycle
    nren = 0; nstall = 0; base = m_cnt;
    memW = 0;
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3);
      memW = (i == 3);
      cycle();
      nren += int'(o_ren); nstall += int'(o_stall);
    end
    chk("lw_miss_ren_cycles", nren, 4);
    chk("lw_miss_stall_cycles", nstall, 3);
    chk("lw_miss_cnt", {16'd0, stallcnt}, base[31:0] + 32'd3);

    // Held result across a frozen pipeline
    dhit = 1; memW = 0; dmemload = 32'hDEADBEEF;
    cycle();
    dhit = 0; dmemload = 32'h0;
    cycle();
    chk("held_load", memdmemload, 32'hDEADBEEF);
    chk("held_ren", {31'd0, dmemREN}, 32'd0);
    memW = 1;
    cycle();

    // LL/SC success
    idle_in();
    memMemRead = 1; memLL = 1; memaddr = 32'h200; dhit = 1; dmemload = 32'h55;
    cycle();
    idle_in();
    memMemWrite = 1; memSC = 1; memaddr = 32'h200; memstore = 32'h77; dhit = 1;
    #3;
    chk("sc_ok_wen", {31'd0, dmemWEN}, 32'd1);
    chk("sc_ok_load", memdmemload, 32'd1);
    #2; @(negedge CLK); @(posedge CLK);
    idle_in();
    #1;
    m_lv = 0;

    // LL then snoop invalidate then SC fails
    memMemRead = 1; memLL = 1; memaddr = 32'h200; dhit = 1;
    cycle();
    idle_in();
    ccinv = 1; ccsnoopaddr = 32'h200;
    cycle();
    idle_in();
    memMemWrite = 1; memSC = 1; memaddr = 32'h200;
    cycle();
    chk("sc_fail_stall", {31'd0, o_stall}, 32'd0);
    chk("sc_fail_load", e_load, 32'd0);

    // Flush while in DONE keeps the link from the held LL
    idle_in();
    memMemRead = 1; memLL = 1; memaddr = 32'h300; dhit = 1; dmemload = 32'h1234; memW = 0;
    cycle();
    dhit = 0; memW = 1; memRST = 1;
    cycle();
    idle_in();
    memMemWrite = 1; memSC = 1; memaddr = 32'h300; dhit = 1;
    cycle();
    chk("flush_link_kept", e_load, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int kind;
      idle_in();
      kind = $urandom_range(0, 4);
      memaddr  = 32'h100 * $urandom_range(1, 4);
      memstore = $urandom;
      dmemload = $urandom;
      case (kind)
        1: memMemRead = 1;
        2: begin memMemRead = 1; memLL = 1; end
        3: memMemWrite = 1;
        4: begin memMemWrite = 1; memSC = 1; end
        default: ;
      endcase
      dhit   = ($urandom_range(0, 1) == 1);
      memW   = ($urandom_range(0, 9) < 7);
      memRST = ($urandom_range(0, 9) == 0);
      ccinv  = ($urandom_range(0, 6) == 0);
      ccsnoopaddr = 32'h100 * $urandom_range(1, 4);
      cycle();
    end

    // Reset during a miss drops everything at once
    idle_in();
    memMemRead = 1; memaddr = 32'h400; memW = 0;
    #2;
    nRST = 0;
    #1;
    chk("rst_ren", {31'd0, dmemREN}, 32'd0);
    chk("rst_stall", {31'd0, memStall}, 32'd0);
    chk("rst_load", memdmemload, 32'd0);
    chk("rst_cnt", {16'd0, stallcnt}, 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1;
    for (int i = 0; i < 65536 + 3; i++) begin
      @(posedge CLK);
      if (m_cnt < 65535) m_cnt++;
    end
    #1;
    chk("sat_cnt", {16'd0, stallcnt}, 32'h0000FFFF);
    chk("sat_model", {16'd0, stallcnt}, m_cnt[31:0]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage data-access controller between the EX/MEM latch and the MEM/WB latch. It drives the data-cache request for loads and stores, stalls the pipeline until `dhit`, and holds returned load data if the pipeline cannot advance. It also owns the LL/SC link register and counts stall cycles. Its `memdmemload` output feeds the MEM/WB latch directly.

## Interface
- `CNTW`, default 16: width of the saturating stall-cycle counter.
- `CLK`  in  1  clock; all state updates on posedge.
- `nRST`  in  1  asynchronous reset, active-low.
- `memMemRead`  in  1  load (LW or LL) in MEM stage.
- `memMemWrite`  in  1  store (SW or SC) in MEM stage.
- `memLL`, `memSC`  in  1 each  load-linked / store-conditional qualifiers.
- `memaddr`  in  32  word_t effective address from EX/MEM.
- `memstore`  in  32  word_t store data.
- `memW`  in  1  pipeline advance enable, shared with MEM/WB.
- `memRST`  in  1  flush, effective only when `memW`=1.
- `dhit`  in  1  cache completed the current request this cycle.
- `dmemload`  in  32  cache read data, valid when `dhit`=1.
- `ccinv`  in  1  coherence invalidate strobe.
- `ccsnoopaddr`  in  32  invalidate address.
- `dmemREN`, `dmemWEN`  out  1 each  cache read / write request.
- `dmemaddr`, `dmemstore`  out  32  cache address / store data (pass-through of `memaddr` / `memstore`).
- `memdmemload`  out  32  load data or SC result to MEM/WB.
- `memStall`  out  1  to hazard unit; 1 freezes all upstream latches and MEM/WB.
- `stallcnt`  out  CNTW  saturating count of `memStall` cycles.

## Operation
- The current operation `op` = `memMemRead` | `memMemWrite`. The SC-fail condition is `scfail` = `memSC` & (!`linkvalid` | `linkaddr` != `memaddr`).
- The FSM has two states, IDLE and DONE. Reset state is IDLE.
- **IDLE:**
  - `dmemREN` = `memMemRead`.
  - `dmemWEN` = `memMemWrite` & !`scfail`.
  - `memStall` = `op` & !`dhit` & !`scfail`.
  - On completion (`dhit`, or `scfail` with `op`=1):
    - If `memW`=0, capture the result into `hold` and go to DONE.
    - Otherwise stay in IDLE.
- **DONE:**
  - No request is issued and `memStall`=0.
  - `memdmemload` = `hold`.
  - Go to IDLE when `memW`=1.
- **`memdmemload` in IDLE:**
  - `dmemload` for a load.
  - 32'd1 for a successful SC (on `dhit`).
  - 32'd0 for a failed SC.
  - 0 when `op`=0.
- **Link register:**
  - LL with `dhit` sets `linkvalid`=1 and `linkaddr`=`memaddr`.
  - Any completed write (SW or successful SC) to `linkaddr` clears `linkvalid`.
  - `ccinv` with `ccsnoopaddr`==`linkaddr` clears `linkvalid`.
  - A clear and an LL set in the same cycle: the set wins.
- **Flush:** when `memW`=1 and `memRST`=1, go to IDLE, discard `hold`, and make no link update from the flushed op. Requests issued before the flush are not retracted.
- **Stall counter:** `stallcnt` increments once per cycle with `memStall`=1 and saturates at all-ones. No wrap.

## Timing
- **Reset values:**
  - state IDLE, `hold`=0, `linkvalid`=0, `linkaddr`=0, `stallcnt`=0.
  - With inputs at 0, all outputs are 0.
- **Latency:**
  - Cache hit, same-cycle `dhit`: zero stall cycles; data is valid in the cycle it is presented to MEM/WB.
  - Miss returning `dhit` after N cycles: `memStall` is high for exactly N cycles.
- **Outputs:** request outputs and `memdmemload` are combinational from the state and inputs. `hold`, link, FSM and counter are registered.
- **Reset:** reset asserted mid-wait drops the request immediately (asynchronously) and clears the link.

## Structure
- `cpu_types_pkg` gains:
  - `word_t` (already present).
  - `memacc_state_t` enum {IDLE, DONE}.
  - The SC success/fail constants `SC_PASS`=32'd1 and `SC_FAIL`=32'd0.
- The link register (set/clear/compare logic) is the one natural sub-module: `link_reg`.

## Test plan
- **LW hit:** `memMemRead`=1, `memaddr`=0x100, `dhit`=1 with `dmemload`=0xDEADBEEF, `memW`=1 -> `memStall`=0, `memdmemload`=0xDEADBEEF same cycle, `stallcnt` unchanged.
- **LW miss:** `dhit` rises on the 4th cycle -> `memStall`=1 for 3 cycles, `dmemREN` high for 4 cycles, `stallcnt`=3.
- **Held result:** `dhit` with `memW`=0, then `dmemload` changes to 0x0 -> DONE; `memdmemload` stays 0xDEADBEEF with `dmemREN`=0 until `memW`=1.
- **LL/SC:**
  - Success: LL 0x200 hit, then SC 0x200 -> `dmemWEN`=1, `memdmemload`=1 on `dhit`.
  - Fail after snoop: repeat the LL, pulse `ccinv` with `ccsnoopaddr`=0x200, then SC -> `dmemWEN`=0, `memdmemload`=0, no stall.
- **Flush:** `memRST`=1 and `memW`=1 while in DONE -> IDLE next cycle, LL link unchanged.
- **Reset mid-wait:**
  - Drop `nRST` during a miss -> outputs 0 immediately.
  - `stallcnt`=0.
  - Then force 2^CNTW+3 stall cycles -> `stallcnt` saturates at 0xFFFF.
